// File: rtl/fraction_extract_scheduler.sv
// Round-robin scheduler sharing one float-fraction extractor + BCD LUT between requesters.
// Latches a requester's float, sequences the extractor and returns the BCD fraction with a one-cycle Ack.
module fraction_extract_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int LUT_LATENCY    = 2,
  parameter int FIXED_WAIT     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   Main_CLK,
  input  logic                   Main_RST_n,
  input  logic [NUM_REQ-1:0]     Req,
  input  logic [32*NUM_REQ-1:0]  Req_Float,
  output logic [NUM_REQ-1:0]     Ack,
  output logic [7:0]             Resp_BCD,
  output logic                   Resp_Err,
  output logic                   Busy,
  output logic                   Ext_Enable,
  output logic [7:0]             Ext_StartBit,
  output logic [7:0]             Ext_EndBit,
  output logic [7:0]             Ext_Exponent,
  output logic [31:0]            Ext_Input,
  input  logic                   Ext_Valid,
  input  logic [7:0]             Ext_Fraction_BCD
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = 16;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_SETUP, S_RUN, S_SETTLE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [7:0]    resp_bcd_q, resp_bcd_d;
  logic          resp_err_q, resp_err_d;
  logic          busy_q, busy_d;
  logic          ext_en_q, ext_en_d;
  logic [7:0]    start_q, start_d, end_q, end_d, exp_q, exp_d;
  logic [31:0]   input_q, input_d;

  logic          found;
  logic [IW-1:0] gnt_idx;
  logic [31:0]   gnt_float;
  logic [7:0]    gnt_exp, gnt_k, gnt_end, gnt_start;
  logic          gnt_has_frac;
  int            j;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    resp_bcd_d = resp_bcd_q;
    resp_err_d = resp_err_q;
    ext_en_d   = ext_en_q;
    start_d    = start_q;
    end_d      = end_q;
    exp_d      = exp_q;
    input_d    = input_q;

    // Round-robin scan starting at rr_ptr, wrapping at NUM_REQ.
    found   = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!found && Req[j]) begin
        found   = 1'b1;
        gnt_idx = IW'(j);
      end
    end
    gnt_float    = Req_Float[int'(gnt_idx)*32 +: 32];
    gnt_exp      = gnt_float[30:23];
    gnt_k        = gnt_exp - 8'd127;
    gnt_has_frac = (gnt_exp > 8'd127) && (gnt_exp != 8'd255) && (gnt_k < 8'd23);
    gnt_end      = 8'd23 - gnt_k;
    gnt_start    = (gnt_end > 8'd8) ? (gnt_end - 8'd7) : 8'd1;

    case (state_q)
      S_IDLE: if (|Req) state_d = S_ARB;
      S_ARB: begin
        if (found) begin
          idx_d    = gnt_idx;
          rr_ptr_d = (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + IW'(1);
          input_d  = gnt_float;
          exp_d    = gnt_exp;
          start_d  = gnt_has_frac ? gnt_start : 8'd0;
          end_d    = gnt_has_frac ? gnt_end : 8'd0;
          state_d  = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        cnt_d = '0;
        if (exp_q == 8'd255) begin
          resp_err_d = 1'b1;
          resp_bcd_d = 8'hFF;
          state_d    = S_DONE;
        end else if (exp_q > 8'd149) begin
          // k >= 23: the float has no fraction bits, the extractor stays idle.
          resp_err_d = 1'b0;
          resp_bcd_d = 8'h00;
          state_d    = S_DONE;
        end else begin
          ext_en_d = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (((exp_q > 8'd127) && Ext_Valid) ||
            ((exp_q <= 8'd127) && (cnt_q == CW'(FIXED_WAIT-1)))) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES-1)) begin
          ext_en_d   = 1'b0;
          resp_err_d = 1'b1;
          resp_bcd_d = 8'h00;
          state_d    = S_DONE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LUT_LATENCY-1)) begin
          ext_en_d   = 1'b0;
          resp_err_d = 1'b0;
          resp_bcd_d = Ext_Fraction_BCD;
          state_d    = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Ack is registered on entry to DONE so it lasts exactly the DONE cycle.
    if (state_d == S_DONE && state_q != S_DONE) ack_d[idx_q] = 1'b1;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Main_CLK or negedge Main_RST_n) begin
    if (!Main_RST_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      resp_bcd_q <= '0;
      resp_err_q <= 1'b0;
      busy_q     <= 1'b0;
      ext_en_q   <= 1'b0;
      start_q    <= '0;
      end_q      <= '0;
      exp_q      <= '0;
      input_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      resp_bcd_q <= resp_bcd_d;
      resp_err_q <= resp_err_d;
      busy_q     <= busy_d;
      ext_en_q   <= ext_en_d;
      start_q    <= start_d;
      end_q      <= end_d;
      exp_q      <= exp_d;
      input_q    <= input_d;
    end
  end

  assign Ack          = ack_q;
  assign Resp_BCD     = resp_bcd_q;
  assign Resp_Err     = resp_err_q;
  assign Busy         = busy_q;
  assign Ext_Enable   = ext_en_q;
  assign Ext_StartBit = start_q;
  assign Ext_EndBit   = end_q;
  assign Ext_Exponent = exp_q;
  assign Ext_Input    = input_q;
endmodule

// File: tb/tb_fraction_extract_scheduler.sv
// Directed bench for fraction_extract_scheduler: extractor model, expected-response queue and Ack monitor.
// Queue entries hold {index, err, bcd, enabled-cycle count} for each expected Ack.
module tb_fraction_extract_scheduler;
  localparam int NUM_REQ = 4;

  logic                  Main_CLK = 1'b0;
  logic                  Main_RST_n = 1'b0;
  logic [NUM_REQ-1:0]    Req = '0;
  logic [32*NUM_REQ-1:0] Req_Float = '0;
  logic [NUM_REQ-1:0]    Ack;
  logic [7:0]            Resp_BCD;
  logic                  Resp_Err;
  logic                  Busy;
  logic                  Ext_Enable;
  logic [7:0]            Ext_StartBit, Ext_EndBit, Ext_Exponent;
  logic [31:0]           Ext_Input;
  logic                  Ext_Valid = 1'b0;
  logic [7:0]            Ext_Fraction_BCD = 8'h00;

  fraction_extract_scheduler #(.NUM_REQ(NUM_REQ), .LUT_LATENCY(2), .FIXED_WAIT(2), .TIMEOUT_CYCLES(64)) dut (
    .Main_CLK(Main_CLK), .Main_RST_n(Main_RST_n), .Req(Req), .Req_Float(Req_Float),
    .Ack(Ack), .Resp_BCD(Resp_BCD), .Resp_Err(Resp_Err), .Busy(Busy),
    .Ext_Enable(Ext_Enable), .Ext_StartBit(Ext_StartBit), .Ext_EndBit(Ext_EndBit),
    .Ext_Exponent(Ext_Exponent), .Ext_Input(Ext_Input),
    .Ext_Valid(Ext_Valid), .Ext_Fraction_BCD(Ext_Fraction_BCD)
  );

  always #5 Main_CLK = ~Main_CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int valid_after = 1000;
  int valid_cyc   = 0;
  int ack_count   = 0;
  int last_ack_cyc = 0;
  logic [19:0] exp_q[$];

  always @(posedge Main_CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Extractor model: Valid after valid_after enabled cycles, BCD from a small hand table.
  initial begin
    int en_cnt;
    en_cnt = 0;
    forever begin
      @(negedge Main_CLK);
      if (!Main_RST_n || !Ext_Enable) begin
        en_cnt = 0;
        Ext_Valid = 1'b0;
      end else begin
        en_cnt++;
        if (en_cnt >= valid_after) begin
          if (!Ext_Valid) valid_cyc = cyc;
          Ext_Valid = 1'b1;
        end
      end
      case (Ext_Input)
        32'h40200000: Ext_Fraction_BCD = 8'h50;
        32'h3F400000: Ext_Fraction_BCD = 8'h75;
        32'h3FA00000: Ext_Fraction_BCD = 8'h25;
        default:      Ext_Fraction_BCD = 8'h00;
      endcase
    end
  end

  // Monitor: pops one expected entry per Ack, checks enable gaps between jobs.
  initial begin
    int en_run, low_run;
    logic prev_en, prev_ack;
    logic [19:0] e;
    int idx;
    en_run = 0; low_run = 100; prev_en = 1'b0; prev_ack = 1'b0;
    forever begin
      @(negedge Main_CLK);
      if (!Main_RST_n) begin
        en_run = 0; low_run = 100; prev_en = 1'b0; prev_ack = 1'b0;
      end else begin
        if (Ext_Enable && !prev_en) check("enable_low_gap_ge2", 32'(low_run >= 2), 32'd1);
        if (Ext_Enable) begin en_run++; low_run = 0; end
        else low_run++;
        prev_en = Ext_Enable;
        if (|Ack) begin
          check("ack_onehot", 32'($countones(Ack)), 32'd1);
          check("ack_not_back_to_back", 32'(prev_ack), 32'd0);
          idx = 0;
          for (int i = 0; i < NUM_REQ; i++) if (Ack[i]) idx = i;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_ack: Ack=0x%0h with empty queue", Ack);
          end else begin
            e = exp_q.pop_front();
            check("ack_index", 32'(idx), 32'(e[19:17]));
            check("resp_err", 32'(Resp_Err), 32'(e[16]));
            check("resp_bcd", 32'(Resp_BCD), 32'(e[15:8]));
            check("enabled_cycles", 32'(en_run), 32'(e[7:0]));
          end
          en_run = 0;
          ack_count++;
          last_ack_cyc = cyc;
        end
        prev_ack = |Ack;
      end
    end
  end

  function automatic logic [19:0] pack(input int idx, input logic err, input logic [7:0] bcd, input int en);
    return {3'(idx), err, bcd, 8'(en)};
  endfunction

  task automatic wait_acks(input int n, input int budget);
    int c;
    c = 0;
    while (ack_count < n && c < budget) begin
      @(negedge Main_CLK);
      c++;
    end
    @(negedge Main_CLK);
    if (ack_count < n) begin
      n_checks++; n_fail++;
      $display("FAIL ack_timeout: got %0d acks, expected %0d", ack_count, n);
    end
  endtask

  // Issue a single request, hold it through ARB, then release.
  task automatic issue(input int i, input logic [31:0] f, input int va, output int drive_cyc);
    valid_after = va;
    Req_Float[32*i +: 32] = f;
    @(negedge Main_CLK);
    Req[i] = 1'b1;
    drive_cyc = cyc;
    repeat (2) @(negedge Main_CLK);
    Req[i] = 1'b0;
  endtask

  initial begin
    int dc, base;
    repeat (2) @(negedge Main_CLK);
    check("rst_ack", 32'(Ack), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_enable", 32'(Ext_Enable), 32'd0);
    check("rst_resp_bcd", 32'(Resp_BCD), 32'd0);
    check("rst_resp_err", 32'(Resp_Err), 32'd0);
    check("rst_ext_input", Ext_Input, 32'd0);
    check("rst_exponent", 32'(Ext_Exponent), 32'd0);
    check("rst_startbit", 32'(Ext_StartBit), 32'd0);
    check("rst_endbit", 32'(Ext_EndBit), 32'd0);
    Main_RST_n = 1'b1;

    // 1: 2.5, exponent 128, bits 15..22, Valid after 8 enabled cycles.
    base = ack_count;
    exp_q.push_back(pack(0, 1'b0, 8'h50, 10));
    issue(0, 32'h40200000, 8, dc);
    check("t1_exponent", 32'(Ext_Exponent), 32'd128);
    check("t1_startbit", 32'(Ext_StartBit), 32'd15);
    check("t1_endbit", 32'(Ext_EndBit), 32'd22);
    check("t1_ext_input", Ext_Input, 32'h40200000);
    wait_acks(base + 1, 100);
    check("t1_ack_after_valid", 32'(last_ack_cyc - valid_cyc), 32'd3);

    // 2: k=24, no fraction bits.
    base = ack_count;
    exp_q.push_back(pack(1, 1'b0, 8'h00, 0));
    issue(1, 32'h4B800000, 1, dc);
    wait_acks(base + 1, 50);
    check("t2_ack_latency", 32'(last_ack_cyc - dc), 32'd3);

    // 3: 0.75, e=126, fixed wait, Valid asserted early and ignored.
    base = ack_count;
    exp_q.push_back(pack(2, 1'b0, 8'h75, 4));
    issue(2, 32'h3F400000, 1, dc);
    check("t3_startbit", 32'(Ext_StartBit), 32'd0);
    check("t3_endbit", 32'(Ext_EndBit), 32'd0);
    wait_acks(base + 1, 50);

    // 4: all requesters held after reset: order 0,1,2,3,0.
    @(negedge Main_CLK);
    Main_RST_n = 1'b0;
    @(negedge Main_CLK);
    Main_RST_n = 1'b1;
    base = ack_count;
    valid_after = 3;
    Req_Float[0  +: 32] = 32'h40200000;
    Req_Float[32 +: 32] = 32'h3F400000;
    Req_Float[64 +: 32] = 32'h3FA00000;
    Req_Float[96 +: 32] = 32'h4B800000;
    exp_q.push_back(pack(0, 1'b0, 8'h50, 5));
    exp_q.push_back(pack(1, 1'b0, 8'h75, 4));
    exp_q.push_back(pack(2, 1'b0, 8'h25, 4));
    exp_q.push_back(pack(3, 1'b0, 8'h00, 0));
    exp_q.push_back(pack(0, 1'b0, 8'h50, 5));
    Req = 4'b1111;
    begin
      int c;
      c = 0;
      while (ack_count < base + 5 && c < 300) begin
        @(negedge Main_CLK);
        c++;
      end
    end
    Req = 4'b0000;
    repeat (4) @(negedge Main_CLK);
    check("t4_ack_count", 32'(ack_count - base), 32'd5);

    // 5: Valid stuck low -> timeout; then Inf.
    base = ack_count;
    exp_q.push_back(pack(0, 1'b1, 8'h00, 64));
    issue(0, 32'h40200000, 1000, dc);
    wait_acks(base + 1, 200);
    exp_q.push_back(pack(1, 1'b1, 8'hFF, 0));
    issue(1, 32'h7F800000, 1, dc);
    wait_acks(base + 2, 50);

    // 6: reset during SETTLE abandons the job; pending Req[3] served afterwards.
    issue(0, 32'h40200000, 3, dc);
    begin
      int c;
      c = 0;
      while (!Ext_Valid && c < 50) begin
        @(negedge Main_CLK);
        c++;
      end
      check("t6_valid_seen", 32'(Ext_Valid), 32'd1);
    end
    @(posedge Main_CLK);
    #2;
    Main_RST_n = 1'b0;
    #1;
    check("t6_rst_ack", 32'(Ack), 32'd0);
    check("t6_rst_busy", 32'(Busy), 32'd0);
    check("t6_rst_enable", 32'(Ext_Enable), 32'd0);
    check("t6_rst_resp_bcd", 32'(Resp_BCD), 32'd0);
    check("t6_rst_ext_input", Ext_Input, 32'd0);
    check("t6_rst_exponent", 32'(Ext_Exponent), 32'd0);
    Req_Float[96 +: 32] = 32'h3F400000;
    Req = 4'b1000;
    base = ack_count;
    exp_q.push_back(pack(3, 1'b0, 8'h75, 4));
    repeat (2) @(negedge Main_CLK);
    Main_RST_n = 1'b1;
    repeat (3) @(negedge Main_CLK);
    Req = 4'b0000;
    wait_acks(base + 1, 50);

    repeat (5) @(negedge Main_CLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fraction_extract_scheduler.md
Name: fraction_extract_scheduler

Overview:
- Shares one bit-range extractor (float-fraction extractor plus fraction BCD LUT) between NUM_REQ readout requesters, e.g. the Vmax, Vmin, Vpp and frequency display channels.
- Round-robin arbitrates requests and latches the requester's IEEE-754 single.
- Derives the exponent and start/end bit numbers, enables and sequences the extractor, waits out the LUT latency, and returns the BCD fraction with a one-cycle Ack.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LUT_LATENCY, 2, cycles from extractor valid/ready to a stable Ext_Fraction_BCD
FIXED_WAIT, 2, enabled cycles before the settle phase when exponent <= 127
TIMEOUT_CYCLES, 64, maximum cycles in RUN waiting for Ext_Valid

Ports:
Main_CLK  in  1  system clock, all logic on rising edge
Main_RST_n  in  1  asynchronous active-low reset
Req  in  NUM_REQ  per-requester request level
Req_Float  in  32*NUM_REQ  float word of requester i at [32i+31:32i]
Ack  out  NUM_REQ  one-cycle pulse to the served requester
Resp_BCD  out  8  BCD fraction, valid in the Ack cycle, held until the next Ack
Resp_Err  out  1  error qualifier, valid with Ack
Busy  out  1  high in any state other than IDLE
Ext_Enable  out  1  extractor Module_Enable
Ext_StartBit  out  8  first bit number, 1-based
Ext_EndBit  out  8  last bit number, 1-based
Ext_Exponent  out  8  float[30:23] of the latched job
Ext_Input  out  32  latched raw float word
Ext_Valid  in  1  extractor Valid_Output, sampled on the rising edge
Ext_Fraction_BCD  in  8  LUT output

Behaviour:
- Reset (asynchronous, Main_RST_n=0):
  - state=IDLE, rr_ptr=0.
  - Ack, Resp_BCD, Resp_Err, Busy, Ext_Enable, Ext_StartBit, Ext_EndBit, Ext_Exponent and Ext_Input all 0.
  - Reset mid-job abandons the job with no Ack.
- IDLE: if any Req is set, go to ARB.
- ARB (1 cycle):
  - Grant the first set Req scanning from rr_ptr upward, with wrap.
  - Latch its Req_Float and index; rr_ptr <= index+1 mod NUM_REQ.
  - If no Req is set in this cycle, return to IDLE.
- SETUP (1 cycle): drive the Ext_* fields with Ext_Enable=0. With e=float[30:23]:
  - e==255: next state DONE, Resp_Err=1, Resp_BCD=8'hFF.
  - e>127: k=e-127. If k>=23 (no fraction bits), next state DONE with Resp_BCD=0 and Resp_Err=0; the extractor is never enabled. Otherwise EndBit=23-k, StartBit=max(1, EndBit-7), next state RUN.
  - e<=127: StartBit=0, EndBit=0, next state RUN.
- RUN:
  - Ext_Enable=1; a cycle counter starts at 0.
  - e>127: leave on the first sampled Ext_Valid=1.
  - e<=127: leave after FIXED_WAIT cycles; Ext_Valid is ignored.
  - Then go to SETTLE.
  - If the counter reaches TIMEOUT_CYCLES first: go to DONE with Resp_Err=1 and Resp_BCD=0.
- SETTLE: hold Ext_Enable=1 for LUT_LATENCY cycles, then capture Ext_Fraction_BCD into Resp_BCD and go to DONE.
- DONE (1 cycle): Ext_Enable=0, Ack[idx]=1, then IDLE.
  - DONE guarantees at least 2 enable-low cycles (DONE plus the next job's SETUP) between jobs, so the extractor counters clear.
- Ext_StartBit, Ext_EndBit, Ext_Exponent and Ext_Input stay stable from SETUP through DONE.
- Arithmetic: 8-bit unsigned throughout; the k>=23 check precedes the EndBit subtraction, so EndBit never underflows.
- Dropping Req after ARB does not abort; Ack still pulses. New or held requests during a job wait for the next ARB.
- Total latency ARB→Ack, e>127: 3 + (cycles until Ext_Valid) + LUT_LATENCY.
- Ack is never asserted for two requesters in the same cycle and is never asserted back-to-back for one job.

Test Plan:
1. Req[0]=1 with 0x40200000 (2.5): SETUP drives Exponent=128, StartBit=15, EndBit=22. Model Ext_Valid after 8 enabled cycles and BCD 0x50 → Ack[0] exactly 2 cycles after Valid+1, Resp_BCD=0x50, Resp_Err=0.
2. Req[1]=1 with 0x4B800000 (k=24): Ext_Enable never rises, Ack[1] 3 cycles after Req, Resp_BCD=0x00, Resp_Err=0.
3. Req[2]=1 with 0x3F400000 (0.75, e=126): Ext_Enable high for FIXED_WAIT+LUT_LATENCY=4 cycles, Ext_Valid ignored, Resp_BCD=model BCD.
4. Req=4'b1111 held through 4 jobs with rr_ptr=0: Ack order 0,1,2,3, then 0 again; Ext_Enable low for >=2 cycles between jobs.
5. Ext_Valid stuck 0 on an e>127 job: Ack after 64 RUN cycles, Resp_Err=1, Resp_BCD=0. A 0x7F800000 (Inf) request → Resp_Err=1, Resp_BCD=0xFF, no enable.
6. Main_RST_n pulled low during SETTLE: all outputs 0 immediately, no Ack. After release, a pending Req[3] is served normally starting at rr_ptr=0.
